// File: rtl/qsys_cpu_cpu_mult_seq.sv
// +-----------------------------------------------------------------------------+
// | qsys_cpu_cpu_mult_seq : sequencer driving a 16x16 multiplier cell to form   |
// | 32-bit MUL / MULXUU / MULXSS / MULXSU results.        Revision: 1.0         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module qsys_cpu_cpu_mult_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [31:0] mul_src1,
  output logic [31:0] mul_src2,
  output logic        mul_en,
  input  logic [31:0] mul_p1,
  input  logic [31:0] mul_p2,
  input  logic [31:0] mul_p3
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_P2   = 3'd2,
    S_P3   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] lo_q, lo_d, hh_q, hh_d;
  logic [32:0] mid_q, mid_d;
  logic        mul_en_q, mul_en_d;
  logic [31:0] src1_q, src1_d, src2_q, src2_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic [32:0] w_mid_sum;
  logic [31:0] w_lo, w_hh;
  logic [32:0] w_mid;
  logic [63:0] w_full;
  logic [31:0] w_corr_a, w_corr_b, w_result;

  // In P2 the low/mid products are consumed straight from the cell so that MUL
  // can finish without waiting for the high partial product.
  always_comb begin
    w_mid_sum = {1'b0, mul_p2} + {1'b0, mul_p3};
    w_lo      = (state_q == S_P2) ? mul_p1 : lo_q;
    w_mid     = (state_q == S_P2) ? w_mid_sum : mid_q;
    w_hh      = (state_q == S_P3) ? mul_p1 : hh_q;
    w_full    = {32'h0, w_lo} + {15'h0, w_mid, 16'h0} + {w_hh, 32'h0};
    w_corr_a  = a_q[31] ? b_q : 32'h0;
    w_corr_b  = b_q[31] ? a_q : 32'h0;
    case (op_q)
      OP_MUL:    w_result = w_full[31:0];
      OP_MULXUU: w_result = w_full[63:32];
      OP_MULXSS: w_result = w_full[63:32] - w_corr_a - w_corr_b;
      default:   w_result = w_full[63:32] - w_corr_a;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    lo_d         = lo_q;
    mid_d        = mid_q;
    hh_d         = hh_q;
    mul_en_d     = 1'b0;
    src1_d       = 32'h0;
    src2_d       = 32'h0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          a_d      = req_a;
          b_d      = req_b;
          op_d     = req_op;
          lo_d     = 32'h0;
          mid_d    = 33'h0;
          hh_d     = 32'h0;
          mul_en_d = 1'b1;
          src1_d   = req_a;
          src2_d   = req_b;
          state_d  = S_P1;
        end
      end
      S_P1: begin
        state_d = S_P2;
        if (op_q != OP_MUL) begin
          mul_en_d = 1'b1;
          src1_d   = {16'h0, a_q[31:16]};
          src2_d   = {16'h0, b_q[31:16]};
        end
      end
      S_P2: begin
        lo_d  = mul_p1;
        mid_d = w_mid_sum;
        if (op_q == OP_MUL) begin
          state_d      = S_DONE;
          resp_valid_d = 1'b1;
          resp_data_d  = w_result;
        end else begin
          state_d = S_P3;
        end
      end
      S_P3: begin
        hh_d         = mul_p1;
        state_d      = S_DONE;
        resp_valid_d = 1'b1;
        resp_data_d  = w_result;
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      a_q          <= 32'h0;
      b_q          <= 32'h0;
      op_q         <= 2'b00;
      lo_q         <= 32'h0;
      mid_q        <= 33'h0;
      hh_q         <= 32'h0;
      mul_en_q     <= 1'b0;
      src1_q       <= 32'h0;
      src2_q       <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      mid_q        <= mid_d;
      hh_q         <= hh_d;
      mul_en_q     <= mul_en_d;
      src1_q       <= src1_d;
      src2_q       <= src2_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign mul_en     = mul_en_q;
  assign mul_src1   = src1_q;
  assign mul_src2   = src2_q;

endmodule

`default_nettype wire
